// File: rtl/inv_add_round_key_if.sv
`default_nettype none
// ============================================================================
// Module      : inv_add_round_key_if
// Description : Bundle of data path and key-store signals for the inverse
//               AddRoundKey pipeline stage. The master side drives blocks and
//               key writes; the slave side (the stage itself) returns results.
// Revision    : 1.0  initial release
// ============================================================================
interface inv_add_round_key_if;
  logic         enable;       // capture data_in this cycle
  logic [131:0] data_in;      // [131:128] round header, [127:0] state
  logic [131:0] data_out;     // [131:128] round header, [127:0] state ^ key
  logic         key_wr_en;    // key slot write strobe
  logic [3:0]   key_wr_idx;   // key slot index, 0..9 valid
  logic [127:0] key_wr_data;  // round key
  logic         key_clr;      // clear all slot-valid bits
  logic         key_ready;    // all slots valid
  logic         err;          // one-cycle rejected-block pulse

  modport master (
    output enable, data_in, key_wr_en, key_wr_idx, key_wr_data, key_clr,
    input  data_out, key_ready, err
  );

  modport slave (
    input  enable, data_in, key_wr_en, key_wr_idx, key_wr_data, key_clr,
    output data_out, key_ready, err
  );
endinterface
`default_nettype wire

// File: rtl/inv_add_round_key.sv
`default_nettype none
// ============================================================================
// Module      : inv_add_round_key
// Description : Inverse-cipher AddRoundKey pipeline stage. Holds ten 128-bit
//               round keys with a slot-valid mask and XORs the key selected
//               by the block header (slot = 10 - header) into the state with
//               one cycle of latency. Header 0 is a bubble; out-of-range
//               headers or blocks needing an unloaded key are dropped to zero
//               and flagged with a one-cycle err pulse.
// Revision    : 1.0  initial release
// ============================================================================
module inv_add_round_key (
  input  wire logic             clk,
  input  wire logic             rst,
  inv_add_round_key_if.slave    bus
);

  localparam int         c_NUM_SLOTS = 10;
  localparam logic [3:0] c_MAX_HDR   = 4'd10;

  // --------------------------------------------------------------------------
  // Key store and registered pipeline state
  // --------------------------------------------------------------------------
  logic [127:0]           key_q [c_NUM_SLOTS];
  logic [c_NUM_SLOTS-1:0] valid_q;
  logic [c_NUM_SLOTS-1:0] valid_d;
  logic                   ready_q;
  logic                   ready_d;
  logic [131:0]           data_q;
  logic [131:0]           data_d;
  logic                   err_q;
  logic                   err_d;

  // Combinational view of the incoming block
  logic [3:0]             w_hdr;
  logic [127:0]           w_state;
  logic [3:0]             w_slot;
  logic [127:0]           w_key;
  logic                   w_slot_valid;

  assign w_hdr   = bus.data_in[131:128];
  assign w_state = bus.data_in[127:0];
  assign w_slot  = c_MAX_HDR - w_hdr;

  // Key lookup reads the pre-edge store, so a same-cycle write to the slot
  // being read cannot leak into this cycle's result.
  always_comb begin
    w_key        = '0;
    w_slot_valid = 1'b0;
    for (int i = 0; i < c_NUM_SLOTS; i++) begin
      if (w_slot == 4'(i)) begin
        w_key        = key_q[i];
        w_slot_valid = valid_q[i];
      end
    end
  end

  // Next slot-valid mask: clear dominates any simultaneous write.
  always_comb begin
    valid_d = valid_q;
    if (bus.key_clr) begin
      valid_d = '0;
    end else if (bus.key_wr_en) begin
      for (int i = 0; i < c_NUM_SLOTS; i++) begin
        if (bus.key_wr_idx == 4'(i)) begin
          valid_d[i] = 1'b1;
        end
      end
    end
  end

  // key_ready follows the current mask one cycle later and drops right after
  // a clear without waiting for the mask register to update first.
  always_comb begin
    ready_d = (&valid_q) & ~bus.key_clr;
  end

  // Pipeline register next state: classify the block by header and slot.
  always_comb begin
    data_d = data_q;
    err_d  = 1'b0;
    if (bus.enable) begin
      if (w_hdr == 4'd0) begin
        data_d = '0;
      end else if (w_hdr > c_MAX_HDR) begin
        data_d = '0;
        err_d  = 1'b1;
      end else if (!w_slot_valid) begin
        data_d = '0;
        err_d  = 1'b1;
      end else begin
        data_d = {w_hdr, w_state ^ w_key};
      end
    end
  end

  // Key data carries no reset; only the valid mask decides whether it is used.
  always_ff @(posedge clk) begin
    if (bus.key_wr_en && !bus.key_clr) begin
      for (int i = 0; i < c_NUM_SLOTS; i++) begin
        if (bus.key_wr_idx == 4'(i)) begin
          key_q[i] <= bus.key_wr_data;
        end
      end
    end
  end

  // Control state and the single data pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // A registered bubble header always presents an all-zero word downstream.
  assign bus.data_out  = (data_q[131:128] == 4'd0) ? '0 : data_q;
  assign bus.key_ready = ready_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_add_round_key.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_add_round_key
// Description : Directed self-checking bench for inv_add_round_key.
// Revision    : 1.0  initial release
// ============================================================================
module tb_inv_add_round_key;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [127:0] kexp [10];
  logic [127:0] st;
  logic [3:0]   h;

  inv_add_round_key_if bus_if ();

  inv_add_round_key dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] kinit(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {16{b}};
  endfunction

  function automatic logic [127:0] stpat(input logic [3:0] hh);
    logic [7:0] b;
    b = {hh, ~hh} ^ 8'h5a;
    return {16{b}};
  endfunction

  task automatic wr_key(input logic [3:0] idx, input logic [127:0] k);
    bus_if.key_wr_en   = 1'b1;
    bus_if.key_wr_idx  = idx;
    bus_if.key_wr_data = k;
    tick();
    bus_if.key_wr_en   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.enable      = 1'b0;
    bus_if.data_in     = '0;
    bus_if.key_wr_en   = 1'b0;
    bus_if.key_wr_idx  = '0;
    bus_if.key_wr_data = '0;
    bus_if.key_clr     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_data", bus_if.data_out, '0);
    chk("rst_err", {131'b0, bus_if.err}, '0);
    chk("rst_ready", {131'b0, bus_if.key_ready}, '0);
    rst = 1'b0;

    // Load all ten slots with {16{i}}
    for (int i = 0; i < 10; i++) begin
      kexp[i] = kinit(i);
      wr_key(4'(i), kexp[i]);
    end
    chk("ready_not_yet", {131'b0, bus_if.key_ready}, '0);
    tick();
    chk("ready_rise", {131'b0, bus_if.key_ready}, 132'd1);

    // Slot 3 rewrite, header 7 with all-ones state
    kexp[3] = 128'h000102030405060708090a0b0c0d0e0f;
    wr_key(4'd3, kexp[3]);
    bus_if.enable  = 1'b1;
    bus_if.data_in = {4'd7, {128{1'b1}}};
    tick();
    chk("hdr7_data", bus_if.data_out, {4'd7, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0});
    chk("hdr7_err", {131'b0, bus_if.err}, '0);

    // Bubble, then out-of-range headers 12 and 11
    bus_if.data_in = {4'd0, 128'h1234};
    tick();
    chk("hdr0_data", bus_if.data_out, '0);
    chk("hdr0_err", {131'b0, bus_if.err}, '0);
    bus_if.data_in = {4'd12, 128'h5678};
    tick();
    chk("hdr12_data", bus_if.data_out, '0);
    chk("hdr12_err", {131'b0, bus_if.err}, 132'd1);
    bus_if.data_in = {4'd11, 128'h9abc};
    tick();
    chk("hdr11_data", bus_if.data_out, '0);
    chk("hdr11_err", {131'b0, bus_if.err}, 132'd1);

    // Valid block then enable low: output holds, err low
    bus_if.data_in = {4'd2, 128'hcafef00d_00000000_11111111_22222222};
    tick();
    chk("hdr2_data", bus_if.data_out,
        {4'd2, 128'hcafef00d_00000000_11111111_22222222 ^ kinit(8)});
    bus_if.enable  = 1'b0;
    bus_if.data_in = {4'd9, 128'hffff};
    tick();
    tick();
    chk("hold_data", bus_if.data_out,
        {4'd2, 128'hcafef00d_00000000_11111111_22222222 ^ kinit(8)});
    chk("hold_err", {131'b0, bus_if.err}, '0);

    // Stream headers 1..10, rewriting slot 9 during the header-1 cycle
    bus_if.enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      h  = 4'(i);
      st = stpat(h);
      bus_if.data_in = {h, st};
      if (i == 1) begin
        bus_if.key_wr_en   = 1'b1;
        bus_if.key_wr_idx  = 4'd9;
        bus_if.key_wr_data = 128'hdeadbeef_0badf00d_13572468_a5a5a5a5;
      end
      tick();
      bus_if.key_wr_en = 1'b0;
      chk($sformatf("stream_h%0d", i), {bus_if.err, bus_if.data_out},
          {1'b0, h, st ^ kexp[10 - i]});
      if (i == 1) kexp[9] = 128'hdeadbeef_0badf00d_13572468_a5a5a5a5;
    end
    bus_if.data_in = {4'd1, stpat(4'd1)};
    tick();
    chk("h1_newkey", bus_if.data_out, {4'd1, stpat(4'd1) ^ kexp[9]});

    // key_clr together with a slot-5 write: clear wins
    bus_if.enable      = 1'b0;
    bus_if.key_clr     = 1'b1;
    bus_if.key_wr_en   = 1'b1;
    bus_if.key_wr_idx  = 4'd5;
    bus_if.key_wr_data = '1;
    tick();
    bus_if.key_clr   = 1'b0;
    bus_if.key_wr_en = 1'b0;
    chk("clr_ready", {131'b0, bus_if.key_ready}, '0);
    bus_if.enable  = 1'b1;
    bus_if.data_in = {4'd5, 128'h77};
    tick();
    chk("clr_h5_data", bus_if.data_out, '0);
    chk("clr_h5_err", {131'b0, bus_if.err}, 132'd1);
    bus_if.enable = 1'b0;
    tick();
    chk("err_one_cycle", {131'b0, bus_if.err}, '0);

    // Reload 0..8 plus ignored idx 10: still not ready
    for (int i = 0; i < 9; i++) begin
      kexp[i] = kinit(i);
      wr_key(4'(i), kexp[i]);
    end
    wr_key(4'd10, '1);
    tick();
    chk("idx10_ignored", {131'b0, bus_if.key_ready}, '0);
    kexp[9] = kinit(9);
    wr_key(4'd9, kexp[9]);
    tick();
    chk("reload_ready", {131'b0, bus_if.key_ready}, 132'd1);

    // Mid-stream asynchronous reset
    bus_if.enable  = 1'b1;
    bus_if.data_in = {4'd4, stpat(4'd4)};
    tick();
    chk("pre_rst_h4", bus_if.data_out, {4'd4, stpat(4'd4) ^ kexp[6]});
    bus_if.data_in = {4'd6, stpat(4'd6)};
    rst = 1'b1;
    #1;
    chk("async_rst_data", bus_if.data_out, '0);
    chk("async_rst_ready", {131'b0, bus_if.key_ready}, '0);
    tick();
    rst = 1'b0;
    bus_if.enable = 1'b0;
    tick();
    tick();
    chk("post_rst_data", {bus_if.err, bus_if.key_ready, bus_if.data_out}, '0);
    bus_if.enable  = 1'b1;
    bus_if.data_in = {4'd5, stpat(4'd5)};
    tick();
    chk("post_rst_nokey_data", bus_if.data_out, '0);
    chk("post_rst_nokey_err", {131'b0, bus_if.err}, 132'd1);
    bus_if.enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
